// File: rtl/track_section_arbiter.sv
// Single-track section arbiter: round-robin east/west grant, gate-closed handshake before proceed, CLEAR_CYC-cycle clearance after exit.
// Latency: request to close_req one edge; go follows gate_closed combinationally. Optional watchdog under TRACK_ARB_TIMEOUT_EN.
module track_section_arbiter #(
  parameter int unsigned CLEAR_CYC   = 8,
  parameter int unsigned TIMEOUT_CYC = 200,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_,
  input  logic req_e,
  input  logic req_w,
  input  logic exit_e,
  input  logic exit_w,
  input  logic gate_closed,
  output logic close_req,
  output logic go_e,
  output logic go_w,
  output logic busy,
  output logic owner,
  output logic timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLOSE = 2'd1,
    GRANT = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Elaboration marker: present only when the parameter set is out of range.
  if ((CLEAR_CYC < 1) || (TIMEOUT_CYC < 1) || (CLEAR_CYC > (1 << CNT_W))) begin : g_bad_params
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             cnt_run;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req_e && req_w) begin
          owner_d = ~last_owner_q;
          state_d = CLOSE;
        end else if (req_e) begin
          owner_d = 1'b0;
          state_d = CLOSE;
        end else if (req_w) begin
          owner_d = 1'b1;
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (gate_closed) state_d = GRANT;
      end
      GRANT: begin
        // Only the owning side's exit sensor releases the section.
        if (owner_q ? exit_w : exit_e) begin
          state_d      = CLEAR;
          last_owner_d = owner_q;
        end
      end
      CLEAR: begin
        if (cnt_q == CLR_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TRACK_ARB_TIMEOUT_EN
  assign cnt_run = (state_q == CLEAR) || (state_q == GRANT);
`else
  assign cnt_run = (state_q == CLEAR);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_run && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef TRACK_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic timeout_q, timeout_d;

  always_comb begin
    timeout_d = timeout_q;
    if ((state_q == GRANT) && (cnt_q == TMO_LAST)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign close_req = (state_q == CLOSE) || (state_q == GRANT);
  assign owner     = owner_q;
  // Proceed is gated live by the gate acknowledge so it drops the cycle the gate lifts.
  assign go_e      = (state_q == GRANT) && !owner_q && gate_closed;
  assign go_w      = (state_q == GRANT) &&  owner_q && gate_closed;

endmodule

// File: tb/tb_track_section_arbiter.sv
// Directed bench for track_section_arbiter: grant handshake, round-robin ties, exit filtering, watchdog, async reset.
module tb_track_section_arbiter;

`ifdef TRACK_ARB_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_;
  logic req_e, req_w, exit_e, exit_w, gate_closed;
  logic close_req, go_e, go_w, busy, owner, timeout;

  int checks = 0;
  int errors = 0;

  track_section_arbiter #(
    .CLEAR_CYC  (8),
    .TIMEOUT_CYC(20),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_e      (req_e),
    .req_w      (req_w),
    .exit_e     (exit_e),
    .exit_w     (exit_w),
    .gate_closed(gate_closed),
    .close_req  (close_req),
    .go_e       (go_e),
    .go_w       (go_w),
    .busy       (busy),
    .owner      (owner),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_close_req"}, close_req, 1'b0);
    chk({pfx, "_go_e"},      go_e,      1'b0);
    chk({pfx, "_go_w"},      go_w,      1'b0);
    chk({pfx, "_busy"},      busy,      1'b0);
    chk({pfx, "_owner"},     owner,     1'b0);
    chk({pfx, "_timeout"},   timeout,   1'b0);
  endtask

  initial begin
    rst_ = 1'b1;
    req_e = 1'b0; req_w = 1'b0; exit_e = 1'b0; exit_w = 1'b0; gate_closed = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    chk_reset_outs("rst");
    tick();
    rst_ = 1'b1;

    // Single east request through the full handshake.
    req_e = 1'b1;
    tick();
    chk("t1_close_req", close_req, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_owner", owner, 1'b0);
    chk("t1_go_e_close", go_e, 1'b0);
    gate_closed = 1'b1;
    #1;
    chk("t1_go_e_wait_edge", go_e, 1'b0);
    tick();
    chk("t1_go_e", go_e, 1'b1);
    chk("t1_go_w", go_w, 1'b0);
    chk("t1_owner_grant", owner, 1'b0);
    req_e = 1'b0;
    exit_e = 1'b1;
    tick();
    exit_e = 1'b0;
    gate_closed = 1'b0;
    chk("t1_go_e_clear", go_e, 1'b0);
    chk("t1_close_clear", close_req, 1'b0);
    chk("t1_busy_clear", busy, 1'b1);
    repeat (7) tick();
    chk("t1_busy_k7", busy, 1'b1);
    tick();
    chk("t1_busy_k8", busy, 1'b0);

    // Tie from reset: east first, then west.
    req_e = 1'b1; req_w = 1'b1;
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    tick();
    chk("t2_tie1_busy", busy, 1'b1);
    chk("t2_tie1_owner", owner, 1'b0);
    gate_closed = 1'b1;
    tick();
    chk("t2_tie1_go_e", go_e, 1'b1);
    chk("t2_tie1_go_w", go_w, 1'b0);
    exit_e = 1'b1;
    req_e = 1'b0;
    tick();
    exit_e = 1'b0;
    gate_closed = 1'b0;
    repeat (8) tick();
    chk("t2_idle_after_clear", busy, 1'b0);
    tick();
    chk("t2_w_busy", busy, 1'b1);
    chk("t2_w_owner", owner, 1'b1);
    chk("t2_w_close_req", close_req, 1'b1);
    gate_closed = 1'b1;
    tick();
    chk("t2_w_go_w", go_w, 1'b1);
    chk("t2_w_go_e", go_e, 1'b0);

    // Non-owner exit ignored; go tracks gate_closed combinationally.
    exit_e = 1'b1;
    tick();
    exit_e = 1'b0;
    chk("t3_exit_e_ign_go_w", go_w, 1'b1);
    chk("t3_exit_e_ign_busy", busy, 1'b1);
    gate_closed = 1'b0;
    #1;
    chk("t3_gate_drop_go_w", go_w, 1'b0);
    chk("t3_gate_drop_close", close_req, 1'b1);
    gate_closed = 1'b1;
    #1;
    chk("t3_gate_back_go_w", go_w, 1'b1);
    req_e = 1'b1;
    exit_w = 1'b1;
    tick();
    exit_w = 1'b0;
    gate_closed = 1'b0;
    chk("t3_clear_busy", busy, 1'b1);
    chk("t3_clear_close", close_req, 1'b0);
    chk("t3_clear_go_w", go_w, 1'b0);
    repeat (8) tick();
    chk("t3_idle", busy, 1'b0);
    tick();
    chk("t3_tie3_busy", busy, 1'b1);
    chk("t3_tie3_owner", owner, 1'b0);

    // Watchdog: GRANT held without exit.
    req_e = 1'b0;
    gate_closed = 1'b1;
    tick();
    chk("t4_go_e", go_e, 1'b1);
    repeat (19) tick();
    chk("t4_tmo_before", timeout, 1'b0);
    tick();
    chk("t4_tmo_at20", timeout, TMO_EXP);
    chk("t4_still_grant", go_e, 1'b1);
    exit_e = 1'b1;
    tick();
    exit_e = 1'b0;
    gate_closed = 1'b0;
    chk("t4_exit_honoured", busy, 1'b1);
    chk("t4_exit_go_e", go_e, 1'b0);
    repeat (8) tick();
    chk("t4_idle", busy, 1'b0);
    chk("t4_tmo_sticky", timeout, TMO_EXP);

    // Asynchronous reset mid-GRANT (west pending since test 3).
    tick();
    chk("t5_close_owner", owner, 1'b1);
    gate_closed = 1'b1;
    tick();
    chk("t5_go_w", go_w, 1'b1);
    #2 rst_ = 1'b0;
    #1;
    chk_reset_outs("t5_async");
    gate_closed = 1'b0;
    #1 rst_ = 1'b1;
    tick();
    chk("t5_fresh_busy", busy, 1'b1);
    chk("t5_fresh_owner", owner, 1'b1);
    chk("t5_fresh_close", close_req, 1'b1);
    chk("t5_fresh_go_w", go_w, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
